// File: rtl/slot_ctrl_pkg.sv
// slot_ctrl_pkg: shared definitions for the slot adjustment controller.
//   slot_state_e  controller FSM states
//   REJ_*         reject_code values
//   SLOT_LENGTH   nominal slot terminal count, must match slot_timer
package slot_ctrl_pkg;

    localparam logic [14:0] SLOT_LENGTH = 15'd1624;

    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StIssue       = 2'd1,
        StWaitLoad    = 2'd2,
        StWaitRestore = 2'd3
    } slot_state_e;

    localparam logic [1:0] REJ_RANGE      = 2'b01;
    localparam logic [1:0] REJ_SUPERSEDED = 2'b10;
    localparam logic [1:0] REJ_WDOG       = 2'b11;

endpackage

// File: rtl/slot_len_calc.sv
// slot_len_calc: extends an offset (sign or zero), adds a base length and
// range-checks the 16-bit signed result.
//   i_off    offset, OFF_W bits
//   o_len    low 15 bits of BASE + extended offset
//   o_legal  MIN_LEN <= result <= MAX_LEN
module slot_len_calc #(
    parameter int unsigned OFF_W    = 8,
    parameter bit          SIGN_EXT = 1'b1,
    parameter logic [15:0] BASE     = 16'd0,
    parameter logic [14:0] MIN_LEN  = 15'd100,
    parameter logic [14:0] MAX_LEN  = 15'd3249
) (
    input  logic [OFF_W-1:0] i_off,
    output logic [14:0]      o_len,
    output logic             o_legal
);

    logic [15:0]        w_ext;
    logic signed [15:0] w_sum;

    always_comb begin
        w_ext   = {{(16 - OFF_W){SIGN_EXT & i_off[OFF_W-1]}}, i_off};
        w_sum   = BASE + w_ext;
        // Signed compare so a negative sum counts as below range.
        o_legal = (w_sum >= $signed({1'b0, MIN_LEN})) && (w_sum <= $signed({1'b0, MAX_LEN}));
        o_len   = w_sum[14:0];
    end

endmodule

// File: rtl/slot_adjust_ctrl.sv
// slot_adjust_ctrl: collects DSP (absolute) and tracking (signed delta) slot
// adjust requests, validates and arbitrates them (DSP first), and issues one
// adjust_pos command at a time, then waits for the load and restore slot
// boundaries before allowing the next one.
//   clk_50mhz, cfg_rst          clock, async active-high reset
//   i_slot_start_count          timer running; commands only issued when high
//   i_slot_interrupt            slot boundary pulse from slot_timer
//   i_req_dsp_en/_len           DSP request strobe and absolute length
//   i_req_trk_en/_delta         tracking request strobe and signed delta
//   o_adjust_pos_en/o_adjust_pos  command to slot_timer
//   o_busy, o_grant_dsp, o_grant_trk, o_reject, o_reject_code, o_adjust_count
//   o_debug                     {0, trk len, dsp len, wdog, trk vld, dsp vld, state}
module slot_adjust_ctrl
    import slot_ctrl_pkg::*;
#(
    parameter logic [14:0] MIN_LEN     = 15'd100,
    parameter logic [14:0] MAX_LEN     = 15'd3249,
    parameter logic [23:0] WDOG_CYCLES = 24'd8000000
) (
    input  logic        clk_50mhz,
    input  logic        cfg_rst,
    input  logic        i_slot_start_count,
    input  logic        i_slot_interrupt,
    input  logic        i_req_dsp_en,
    input  logic [14:0] i_req_dsp_len,
    input  logic        i_req_trk_en,
    input  logic [7:0]  i_req_trk_delta,
    output logic        o_adjust_pos_en,
    output logic [31:0] o_adjust_pos,
    output logic        o_busy,
    output logic        o_grant_dsp,
    output logic        o_grant_trk,
    output logic        o_reject,
    output logic [1:0]  o_reject_code,
    output logic [15:0] o_adjust_count,
    output logic [63:0] o_debug
);

    slot_state_e r_state;
    logic        r_dsp_vld, r_trk_vld;
    logic [14:0] r_dsp_len;
    logic [7:0]  r_trk_delta;
    logic [23:0] r_wdog;
    logic [14:0] r_len;
    logic        r_adjust_pos_en, r_busy, r_grant_dsp, r_grant_trk, r_reject;
    logic [1:0]  r_reject_code;
    logic [15:0] r_adjust_count;

    logic [14:0] w_dsp_len, w_trk_len;
    logic        w_dsp_legal, w_trk_legal;

    slot_len_calc #(
        .OFF_W    (15),
        .SIGN_EXT (1'b0),
        .BASE     (16'd0),
        .MIN_LEN  (MIN_LEN),
        .MAX_LEN  (MAX_LEN)
    ) u_dsp_calc (
        .i_off   (r_dsp_len),
        .o_len   (w_dsp_len),
        .o_legal (w_dsp_legal)
    );

    slot_len_calc #(
        .OFF_W    (8),
        .SIGN_EXT (1'b1),
        .BASE     ({1'b0, SLOT_LENGTH}),
        .MIN_LEN  (MIN_LEN),
        .MAX_LEN  (MAX_LEN)
    ) u_trk_calc (
        .i_off   (r_trk_delta),
        .o_len   (w_trk_len),
        .o_legal (w_trk_legal)
    );

    always_ff @(posedge clk_50mhz or posedge cfg_rst) begin
        if (cfg_rst) begin
            r_state         <= StIdle;
            r_dsp_vld       <= 1'b0;
            r_trk_vld       <= 1'b0;
            r_dsp_len       <= '0;
            r_trk_delta     <= '0;
            r_wdog          <= '0;
            r_len           <= '0;
            r_adjust_pos_en <= 1'b0;
            r_busy          <= 1'b0;
            r_grant_dsp     <= 1'b0;
            r_grant_trk     <= 1'b0;
            r_reject        <= 1'b0;
            r_reject_code   <= '0;
            r_adjust_count  <= '0;
        end else begin
            r_adjust_pos_en <= 1'b0;
            r_grant_dsp     <= 1'b0;
            r_grant_trk     <= 1'b0;
            r_reject        <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (r_dsp_vld && !w_dsp_legal) begin
                        r_dsp_vld     <= 1'b0;
                        r_reject      <= 1'b1;
                        r_reject_code <= REJ_RANGE;
                    end else if (r_dsp_vld && i_slot_start_count) begin
                        r_dsp_vld       <= 1'b0;
                        r_len           <= w_dsp_len;
                        r_adjust_pos_en <= 1'b1;
                        r_grant_dsp     <= 1'b1;
                        r_adjust_count  <= r_adjust_count + 16'd1;
                        r_busy          <= 1'b1;
                        r_state         <= StIssue;
                        if (r_trk_vld) begin
                            r_trk_vld     <= 1'b0;
                            r_reject      <= 1'b1;
                            r_reject_code <= REJ_SUPERSEDED;
                        end
                    end else if (r_trk_vld && !w_trk_legal) begin
                        r_trk_vld     <= 1'b0;
                        r_reject      <= 1'b1;
                        r_reject_code <= REJ_RANGE;
                    end else if (r_trk_vld && !r_dsp_vld && i_slot_start_count) begin
                        r_trk_vld       <= 1'b0;
                        r_len           <= w_trk_len;
                        r_adjust_pos_en <= 1'b1;
                        r_grant_trk     <= 1'b1;
                        r_adjust_count  <= r_adjust_count + 16'd1;
                        r_busy          <= 1'b1;
                        r_state         <= StIssue;
                    end
                end
                StIssue: begin
                    // A boundary here precedes the timer latching the command.
                    r_wdog  <= '0;
                    r_state <= StWaitLoad;
                end
                StWaitLoad: begin
                    if (i_slot_interrupt) begin
                        r_wdog  <= '0;
                        r_state <= StWaitRestore;
                    end else if (r_wdog == WDOG_CYCLES - 24'd1) begin
                        r_busy        <= 1'b0;
                        r_reject      <= 1'b1;
                        r_reject_code <= REJ_WDOG;
                        r_state       <= StIdle;
                    end else begin
                        r_wdog <= r_wdog + 24'd1;
                    end
                end
                StWaitRestore: begin
                    if (i_slot_interrupt) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else if (r_wdog == WDOG_CYCLES - 24'd1) begin
                        r_busy        <= 1'b0;
                        r_reject      <= 1'b1;
                        r_reject_code <= REJ_WDOG;
                        r_state       <= StIdle;
                    end else begin
                        r_wdog <= r_wdog + 24'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase

            // Placed after the FSM so a new strobe wins over a same-cycle clear.
            if (i_req_dsp_en) begin
                r_dsp_vld <= 1'b1;
                r_dsp_len <= i_req_dsp_len;
            end
            if (i_req_trk_en) begin
                r_trk_vld   <= 1'b1;
                r_trk_delta <= i_req_trk_delta;
            end
        end
    end

    logic [14:0] w_dsp_dbg, w_trk_dbg;
    assign w_dsp_dbg = r_dsp_vld ? w_dsp_len : 15'd0;
    assign w_trk_dbg = r_trk_vld ? w_trk_len : 15'd0;

    assign o_adjust_pos_en = r_adjust_pos_en;
    assign o_adjust_pos    = {17'd0, r_len};
    assign o_busy          = r_busy;
    assign o_grant_dsp     = r_grant_dsp;
    assign o_grant_trk     = r_grant_trk;
    assign o_reject        = r_reject;
    assign o_reject_code   = r_reject_code;
    assign o_adjust_count  = r_adjust_count;
    assign o_debug         = {6'd0, w_trk_dbg, w_dsp_dbg, r_wdog, r_trk_vld, r_dsp_vld, r_state};

endmodule

// File: tb/tb_slot_adjust_ctrl.sv
module tb_slot_adjust_ctrl;

    logic        clk_50mhz = 1'b0;
    logic        cfg_rst = 1'b1;
    logic        i_slot_start_count = 1'b0;
    logic        i_slot_interrupt = 1'b0;
    logic        i_req_dsp_en = 1'b0;
    logic [14:0] i_req_dsp_len = '0;
    logic        i_req_trk_en = 1'b0;
    logic [7:0]  i_req_trk_delta = '0;
    logic        o_adjust_pos_en;
    logic [31:0] o_adjust_pos;
    logic        o_busy, o_grant_dsp, o_grant_trk, o_reject;
    logic [1:0]  o_reject_code;
    logic [15:0] o_adjust_count;
    logic [63:0] o_debug;

    int n_checks = 0;
    int n_pass = 0;

    // Scoreboards: {is_dsp, len} per expected command, code per expected reject.
    logic [15:0] exp_cmd_q[$];
    logic [1:0]  exp_rej_q[$];

    slot_adjust_ctrl #(
        .MIN_LEN     (15'd100),
        .MAX_LEN     (15'd3249),
        .WDOG_CYCLES (24'd1000)
    ) dut (
        .clk_50mhz          (clk_50mhz),
        .cfg_rst            (cfg_rst),
        .i_slot_start_count (i_slot_start_count),
        .i_slot_interrupt   (i_slot_interrupt),
        .i_req_dsp_en       (i_req_dsp_en),
        .i_req_dsp_len      (i_req_dsp_len),
        .i_req_trk_en       (i_req_trk_en),
        .i_req_trk_delta    (i_req_trk_delta),
        .o_adjust_pos_en    (o_adjust_pos_en),
        .o_adjust_pos       (o_adjust_pos),
        .o_busy             (o_busy),
        .o_grant_dsp        (o_grant_dsp),
        .o_grant_trk        (o_grant_trk),
        .o_reject           (o_reject),
        .o_reject_code      (o_reject_code),
        .o_adjust_count     (o_adjust_count),
        .o_debug            (o_debug)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic dsp_req(input logic [14:0] len);
        i_req_dsp_en  = 1'b1;
        i_req_dsp_len = len;
        tick();
        i_req_dsp_en  = 1'b0;
    endtask

    task automatic trk_req(input logic [7:0] d);
        i_req_trk_en    = 1'b1;
        i_req_trk_delta = d;
        tick();
        i_req_trk_en    = 1'b0;
    endtask

    task automatic slot_int();
        i_slot_interrupt = 1'b1;
        tick();
        i_slot_interrupt = 1'b0;
    endtask

    // From the ISSUE cycle: step into WAIT_LOAD, then two boundaries.
    task automatic drain(input string tag);
        tick();
        slot_int();
        slot_int();
        chk(tag, {63'd0, o_busy}, 64'd0);
    endtask

    // Monitor: compare every command and reject against the scoreboards.
    always @(negedge clk_50mhz) begin
        if (!cfg_rst) begin
            if (o_adjust_pos_en) begin
                if (exp_cmd_q.size() == 0) begin
                    chk("cmd_unexpected", 64'(o_adjust_pos), 64'hFFFF_FFFF);
                end else begin
                    logic [15:0] e;
                    e = exp_cmd_q.pop_front();
                    chk("cmd_pos", 64'(o_adjust_pos), {49'd0, e[14:0]});
                    chk("cmd_grant_dsp", {63'd0, o_grant_dsp}, {63'd0, e[15]});
                    chk("cmd_grant_trk", {63'd0, o_grant_trk}, {63'd0, ~e[15]});
                end
            end
            if (o_reject) begin
                if (exp_rej_q.size() == 0) begin
                    chk("rej_unexpected", {62'd0, o_reject_code}, 64'hF);
                end else begin
                    chk("rej_code", {62'd0, o_reject_code}, {62'd0, exp_rej_q.pop_front()});
                end
            end
        end
    end

    initial begin
        int n;
        // Reset state
        repeat (3) tick();
        chk("rst_outputs", {o_adjust_pos_en, o_busy, o_grant_dsp, o_grant_trk, o_reject,
                            o_reject_code, o_adjust_count}, 64'd0);
        chk("rst_pos", 64'(o_adjust_pos), 64'd0);
        chk("rst_debug", o_debug, 64'd0);
        cfg_rst = 1'b0;
        i_slot_start_count = 1'b1;
        tick();
        chk("post_rst_en", {63'd0, o_adjust_pos_en}, 64'd0);

        // DSP 1200: latency and full command lifetime
        exp_cmd_q.push_back({1'b1, 15'd1200});
        dsp_req(15'd1200);
        chk("lat_en_t", {63'd0, o_adjust_pos_en}, 64'd0);
        tick();
        chk("lat_en_t1", {63'd0, o_adjust_pos_en}, 64'd1);
        chk("busy_issue", {63'd0, o_busy}, 64'd1);
        tick();
        chk("en_one_cycle", {63'd0, o_adjust_pos_en}, 64'd0);
        repeat (5) tick();
        slot_int();
        chk("busy_restore", {63'd0, o_busy}, 64'd1);
        chk("state_restore", {62'd0, o_debug[1:0]}, 64'd3);
        slot_int();
        chk("busy_done", {63'd0, o_busy}, 64'd0);
        chk("count_1", 64'(o_adjust_count), 64'd1);

        // Tracking deltas around nominal
        exp_cmd_q.push_back({1'b0, 15'd1600});
        trk_req(-8'sd24);
        tick();
        drain("trk_neg_done");
        exp_cmd_q.push_back({1'b0, 15'd1751});
        trk_req(8'sd127);
        tick();
        drain("trk_pos_done");

        // Out-of-range DSP lengths
        exp_rej_q.push_back(2'b01);
        dsp_req(15'd50);
        tick();
        chk("rej_lo_pulse", {63'd0, o_reject}, 64'd1);
        chk("rej_lo_busy", {63'd0, o_busy}, 64'd0);
        exp_rej_q.push_back(2'b01);
        dsp_req(15'd4000);
        repeat (3) tick();
        chk("rej_hi_held", {62'd0, o_reject_code}, 64'd1);
        chk("rej_hi_busy", {63'd0, o_busy}, 64'd0);

        // Simultaneous DSP and tracking: DSP wins, tracking superseded
        exp_cmd_q.push_back({1'b1, 15'd1000});
        exp_rej_q.push_back(2'b10);
        i_req_dsp_en = 1'b1; i_req_dsp_len = 15'd1000;
        i_req_trk_en = 1'b1; i_req_trk_delta = 8'sd5;
        tick();
        i_req_dsp_en = 1'b0; i_req_trk_en = 1'b0;
        tick();
        drain("both_done");
        repeat (3) tick();
        chk("both_count", 64'(o_adjust_count), 64'd4);

        // Held off while the timer is not running
        i_slot_start_count = 1'b0;
        exp_cmd_q.push_back({1'b1, 15'd700});
        dsp_req(15'd700);
        repeat (3) tick();
        chk("stopped_busy", {63'd0, o_busy}, 64'd0);
        i_slot_start_count = 1'b1;
        tick();
        drain("stopped_done");

        // Boundary in ISSUE ignored; requests while busy use the latest length
        exp_cmd_q.push_back({1'b1, 15'd2000});
        dsp_req(15'd2000);
        tick();
        slot_int();
        chk("issue_int_ignored", {62'd0, o_debug[1:0]}, 64'd2);
        exp_cmd_q.push_back({1'b1, 15'd600});
        dsp_req(15'd500);
        dsp_req(15'd600);
        slot_int();
        slot_int();
        tick();
        chk("latest_issued", 64'(o_adjust_pos), 64'd600);
        drain("latest_done");

        // Watchdog timeout in WAIT_LOAD
        exp_cmd_q.push_back({1'b1, 15'd1500});
        dsp_req(15'd1500);
        tick();
        tick();
        exp_rej_q.push_back(2'b11);
        n = 0;
        for (int i = 0; i < 1200 && o_busy; i++) begin
            tick();
            n++;
        end
        chk("wdog_idle", {63'd0, o_busy}, 64'd0);
        chk("wdog_cycles", 64'(n), 64'd1000);
        chk("wdog_code", {62'd0, o_reject_code}, 64'd3);
        chk("wdog_count", 64'(o_adjust_count), 64'd8);

        // Reset during WAIT_LOAD clears everything, including a pending entry
        exp_cmd_q.push_back({1'b1, 15'd1300});
        dsp_req(15'd1300);
        tick();
        trk_req(8'd0);
        cfg_rst = 1'b1;
        #1;
        chk("midrst_outputs", {o_adjust_pos_en, o_busy, o_grant_dsp, o_grant_trk, o_reject,
                               o_reject_code, o_adjust_count}, 64'd0);
        chk("midrst_pos", 64'(o_adjust_pos), 64'd0);
        chk("midrst_debug", o_debug, 64'd0);
        tick();
        cfg_rst = 1'b0;
        repeat (4) tick();
        chk("midrst_no_cmd", {63'd0, o_busy}, 64'd0);

        chk("cmd_q_empty", 64'(exp_cmd_q.size()), 64'd0);
        chk("rej_q_empty", 64'(exp_rej_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
